// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle RV32I data memory responder with fixed wait states
// Optional misaligned-access trapping is enabled by defining MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_W_En,
    input  logic [2:0]  Req_Funct3,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_W_Data,
    output logic        Resp_Valid,
    input  logic        Resp_Ready,
    output logic [31:0] Resp_Data_Ext,
    output logic        Resp_Err,
    output logic        Busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state, state_next;
    logic [2:0]     cnt;
    logic [AW+1:0]  lat_addr;
    logic [2:0]     lat_f3;
    logic [31:0]    lat_wdata;
    logic           lat_wen;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           hs, access, write_en;
    logic [AW+1:0]  a_addr;
    logic [2:0]     a_f3;
    logic [31:0]    a_wdata;
    logic           a_wen;
    logic [1:0]     lo;
    logic           misaligned, illegal, err;
    logic [31:0]    rd_word, ld_data, wd;
    logic [7:0]     rd_byte;
    logic [15:0]    rd_half;
    logic [3:0]     be;
    logic           unused_addr;

    assign unused_addr = &{1'b0, Req_Addr[31:AW+2]};
    assign hs = Req_Valid && Req_Ready;

    // With zero wait states the access happens on the accept edge, straight from the request inputs.
    assign access = (state == S_WAIT && cnt == 3'd0) ||
                    (state == S_IDLE && hs && WAIT_STATES == 0);
    assign a_addr  = (state == S_IDLE) ? Req_Addr[AW+1:0] : lat_addr;
    assign a_f3    = (state == S_IDLE) ? Req_Funct3 : lat_f3;
    assign a_wdata = (state == S_IDLE) ? Req_W_Data : lat_wdata;
    assign a_wen   = (state == S_IDLE) ? Req_W_En : lat_wen;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        Req_Ready  = 1'b0;
        Resp_Valid = 1'b0;
        Busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                Req_Ready = !RST;
                if (hs) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: if (cnt == 3'd0) state_next = S_RESP;
            S_RESP: begin
                Resp_Valid = 1'b1;
                if (Resp_Ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Halves and words use aligned lanes; the dropped low bits only matter when trapping.
    always_comb begin
        lo         = a_addr[1:0];
        misaligned = 1'b0;
        case (a_f3[1:0])
            2'b01: begin misaligned = a_addr[0];    lo = {a_addr[1], 1'b0}; end
            2'b10: begin misaligned = |a_addr[1:0]; lo = 2'b00;             end
            default: ;
        endcase
        case (a_f3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = a_wen;
            default:                illegal = 1'b1;
        endcase
        err = illegal || (TRAP_EN && misaligned);
    end

    assign rd_word = mem[a_addr[AW+1:2]];
    assign rd_half = lo[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (lo)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        case (a_f3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_data = {24'd0, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_data = {16'd0, rd_half};
            default: ld_data = rd_word;
        endcase
        be = 4'b0000;
        wd = a_wdata;
        case (a_f3)
            3'b000: begin be = 4'b0001 << lo; wd = {4{a_wdata[7:0]}};  end
            3'b001: begin be = 4'b0011 << lo; wd = {2{a_wdata[15:0]}}; end
            3'b010: be = 4'b1111;
            default: ;
        endcase
    end

    assign write_en = access && a_wen && !err;

    always_ff @(posedge CLK) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[a_addr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt           <= 3'd0;
            lat_addr      <= '0;
            lat_f3        <= 3'd0;
            lat_wdata     <= 32'd0;
            lat_wen       <= 1'b0;
            Resp_Data_Ext <= 32'd0;
            Resp_Err      <= 1'b0;
        end else begin
            if (hs) begin
                lat_addr  <= Req_Addr[AW+1:0];
                lat_f3    <= Req_Funct3;
                lat_wdata <= Req_W_Data;
                lat_wen   <= Req_W_En;
                cnt       <= CNT_INIT;
            end else if (state == S_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (access) begin
                Resp_Err      <= err;
                Resp_Data_Ext <= (err || a_wen) ? 32'd0 : ld_data;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
    localparam int WS      = 2;
    localparam int EXP_LAT = WS + 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Req_Valid = 1'b0;
    logic        Req_Ready;
    logic        Req_W_En = 1'b0;
    logic [2:0]  Req_Funct3 = 3'd0;
    logic [31:0] Req_Addr = 32'd0;
    logic [31:0] Req_W_Data = 32'd0;
    logic        Resp_Valid;
    logic        Resp_Ready = 1'b0;
    logic [31:0] Resp_Data_Ext;
    logic        Resp_Err;
    logic        Busy;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
        .CLK(CLK), .RST(RST),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_W_En(Req_W_En),
        .Req_Funct3(Req_Funct3), .Req_Addr(Req_Addr), .Req_W_Data(Req_W_Data),
        .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready),
        .Resp_Data_Ext(Resp_Data_Ext), .Resp_Err(Resp_Err), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic req_resp(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] data,
                            output logic err, output int lat);
        int guard;
        @(negedge CLK);
        Req_Valid = 1'b1; Req_W_En = wen; Req_Funct3 = f3; Req_Addr = addr; Req_W_Data = wdata;
        guard = 0;
        while (!Req_Ready && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        @(posedge CLK);
        #1 Req_Valid = 1'b0;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!Resp_Valid && lat < 20);
        data = Resp_Data_Ext;
        err  = Resp_Err;
        Resp_Ready = 1'b1;
        @(posedge CLK);
        #1 Resp_Ready = 1'b0;
    endtask

    task automatic check_access(input string name, input logic [31:0] data, input logic err,
                                input int lat, input logic [31:0] exp_data, input logic exp_err);
        n_checks++;
        if (data !== exp_data || err !== exp_err || lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL %s: data=%h err=%b lat=%0d, required data=%h err=%b lat=%0d",
                     name, data, err, lat, exp_data, exp_err, EXP_LAT);
        end
    endtask

    task automatic test_reset;
        int busy_seen;
        Req_Valid = 1'b1; Req_W_En = 1'b1; Req_Funct3 = 3'b010;
        Req_Addr = 32'h40; Req_W_Data = 32'h99999999;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({Busy, Resp_Valid, Resp_Err, Req_Ready} !== 4'b0000 || Resp_Data_Ext !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: busy=%b rv=%b err=%b rr=%b data=%h, required all 0",
                         Busy, Resp_Valid, Resp_Err, Req_Ready, Resp_Data_Ext);
            end
        end
        RST = 1'b0; Req_Valid = 1'b0;
        #1;
        n_checks++;
        if (Req_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: Req_Ready=%b, required 1", Req_Ready);
        end
        busy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (Busy !== 1'b0 || Resp_Valid !== 1'b0) busy_seen++;
        end
        n_checks++;
        if (busy_seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_access: busy/valid seen %0d times, required 0", busy_seen);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] d; logic e; int l;
        req_resp(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, l);
        check_access("sw_0x10", d, e, l, 32'd0, 1'b0);
        req_resp(1'b0, 3'b010, 32'h10, 32'd0, d, e, l);
        check_access("lw_0x10", d, e, l, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_extension;
        logic [31:0] d; logic e; int l;
        req_resp(1'b0, 3'b000, 32'h13, 32'd0, d, e, l);
        check_access("lb_0x13", d, e, l, 32'hFFFFFFDE, 1'b0);
        req_resp(1'b0, 3'b100, 32'h13, 32'd0, d, e, l);
        check_access("lbu_0x13", d, e, l, 32'h000000DE, 1'b0);
        req_resp(1'b0, 3'b001, 32'h12, 32'd0, d, e, l);
        check_access("lh_0x12", d, e, l, 32'hFFFFDEAD, 1'b0);
        req_resp(1'b0, 3'b101, 32'h12, 32'd0, d, e, l);
        check_access("lhu_0x12", d, e, l, 32'h0000DEAD, 1'b0);
        req_resp(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, d, e, l);
        check_access("sb_0x11", d, e, l, 32'd0, 1'b0);
        req_resp(1'b0, 3'b010, 32'h10, 32'd0, d, e, l);
        check_access("lw_after_sb", d, e, l, 32'hDEAD55EF, 1'b0);
        req_resp(1'b0, 3'b010, 32'h1010, 32'd0, d, e, l);
        check_access("lw_wrap_0x1010", d, e, l, 32'hDEAD55EF, 1'b0);
    endtask

    task automatic test_back_to_back;
        int bad; int lat;
        @(negedge CLK);
        Req_Valid = 1'b1; Req_W_En = 1'b0; Req_Funct3 = 3'b010; Req_Addr = 32'h10;
        @(posedge CLK);
        #1 Req_Funct3 = 3'b101;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!Resp_Valid && lat < 20);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge CLK);
            if (Resp_Valid !== 1'b1 || Resp_Data_Ext !== 32'hDEAD55EF || Resp_Err !== 1'b0 ||
                Req_Ready !== 1'b0 || Busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0 || lat != EXP_LAT) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d bad cycles lat=%0d, required 0 bad lat=%0d",
                     bad, lat, EXP_LAT);
        end
        Resp_Ready = 1'b1;
        @(posedge CLK);
        #1 Resp_Ready = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || Req_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_not_accepted: busy=%b rr=%b, required busy=0 rr=1",
                     Busy, Req_Ready);
        end
        @(posedge CLK);
        #1 Req_Valid = 1'b0;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!Resp_Valid && lat < 20);
        check_access("backpressure_next_lhu", Resp_Data_Ext, Resp_Err, lat, 32'h000055EF, 1'b0);
        Resp_Ready = 1'b1;
        @(posedge CLK);
        #1 Resp_Ready = 1'b0;
    endtask

    task automatic test_errors;
        logic [31:0] d; logic e; int l;
        req_resp(1'b0, 3'b011, 32'h10, 32'd0, d, e, l);
        check_access("load_f3_011", d, e, l, 32'd0, 1'b1);
`ifdef MISALIGN_TRAP_EN
        req_resp(1'b0, 3'b010, 32'h12, 32'd0, d, e, l);
        check_access("lw_0x12_trap", d, e, l, 32'd0, 1'b1);
`else
        req_resp(1'b0, 3'b010, 32'h12, 32'd0, d, e, l);
        check_access("lw_0x12_aligned", d, e, l, 32'hDEAD55EF, 1'b0);
`endif
        req_resp(1'b1, 3'b100, 32'h10, 32'h00000077, d, e, l);
        check_access("store_f3_100", d, e, l, 32'd0, 1'b1);
        req_resp(1'b0, 3'b010, 32'h10, 32'd0, d, e, l);
        check_access("lw_after_bad_store", d, e, l, 32'hDEAD55EF, 1'b0);
        req_resp(1'b1, 3'b001, 32'h11, 32'h0000ABCD, d, e, l);
`ifdef MISALIGN_TRAP_EN
        check_access("sh_0x11_trap", d, e, l, 32'd0, 1'b1);
        req_resp(1'b0, 3'b010, 32'h10, 32'd0, d, e, l);
        check_access("lw_after_sh_trap", d, e, l, 32'hDEAD55EF, 1'b0);
`else
        check_access("sh_0x11_aligned", d, e, l, 32'd0, 1'b0);
        req_resp(1'b0, 3'b010, 32'h10, 32'd0, d, e, l);
        check_access("lw_after_sh_aligned", d, e, l, 32'hDEADABCD, 1'b0);
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic e; int l; int seen;
        req_resp(1'b1, 3'b010, 32'h20, 32'h11112222, d, e, l);
        check_access("sw_0x20_seed", d, e, l, 32'd0, 1'b0);
        @(negedge CLK);
        Req_Valid = 1'b1; Req_W_En = 1'b1; Req_Funct3 = 3'b010;
        Req_Addr = 32'h20; Req_W_Data = 32'hCAFEF00D;
        @(posedge CLK);
        #1 Req_Valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        n_checks++;
        if (Busy !== 1'b0 || Resp_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: busy=%b rv=%b, required 0 0", Busy, Resp_Valid);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (Resp_Valid !== 1'b0 || Busy !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_resp: activity seen %0d cycles, required 0", seen);
        end
        req_resp(1'b0, 3'b010, 32'h20, 32'd0, d, e, l);
        check_access("lw_0x20_after_reset", d, e, l, 32'h11112222, 1'b0);
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_extension;
        test_back_to_back;
        test_errors;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
